// File: rtl/rom_scan_pkg.sv
// rom_scan_pkg: shared state encoding and default widths for the ROM scan controller
package rom_scan_pkg;
  localparam int COORD_W = 8;
  localparam int SEL_W = 3;
  localparam int COUNT_W = 17;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
endpackage

// File: rtl/rom_scan_controller_scan_counter_2d.sv
// scan_counter_2d: row-major x/y address counter with limits latched on clear
//   clk, rst_n     : clock, async active-low reset
//   clear          : latch x_lim/y_lim and restart at (0,0)
//   advance        : step to the next coordinate; holds once at (x_lim, y_lim)
//   x, y           : current coordinate
//   at_last        : current coordinate is the final one of the window
module scan_counter_2d #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         advance,
  input  logic [W-1:0] x_lim,
  input  logic [W-1:0] y_lim,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         at_last
);
  logic [W-1:0] xl;
  logic [W-1:0] yl;
  logic         row_end;
  assign row_end = x == xl;
  assign at_last = row_end && y == yl;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x  <= '0;
      y  <= '0;
      xl <= '0;
      yl <= '0;
    end else if (clear) begin
      x  <= '0;
      y  <= '0;
      xl <= x_lim;
      yl <= y_lim;
    end else if (advance && !at_last) begin
      x <= row_end ? '0 : x + W'(1);
      y <= row_end ? y + W'(1) : y;
    end
  end
endmodule

// File: rtl/rom_scan_controller.sv
// rom_scan_controller: scans a window of the pixel ROM and streams pixels over valid/ready
//   start/abort           : scan request (IDLE only) / cancel from any state
//   sel_in,x_last,y_last  : ROM select and inclusive window limits, latched at start
//   xoff,yoff,memorySelect: registered ROM address; pixel is the ROM's combinational data
//   pix_*                 : output stream (valid/ready, data, coordinates, last)
//   busy, done            : not idle / one-cycle completion pulse
//   ones_count            : 1-pixels seen this scan, present only with ROM_SCAN_ONES_COUNT_EN
module rom_scan_controller #(
  parameter int COORD_W = rom_scan_pkg::COORD_W,
  parameter int SEL_W   = rom_scan_pkg::SEL_W,
  parameter int COUNT_W = rom_scan_pkg::COUNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic [COORD_W-1:0] x_last,
  input  logic [COORD_W-1:0] y_last,
  output logic [COORD_W-1:0] xoff,
  output logic [COORD_W-1:0] yoff,
  output logic [SEL_W-1:0]   memorySelect,
  input  logic               pixel,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_data,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_last,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] ones_count
);
  import rom_scan_pkg::*;
  state_t state;
  state_t next_state;
  logic   load;
  logic   clear;
  logic   capture;
  logic   adv;
  logic   finish;
  logic   at_last;
  scan_counter_2d #(.W(COORD_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .advance (adv),
    .x_lim   (x_last),
    .y_lim   (y_last),
    .x       (xoff),
    .y       (yoff),
    .at_last (at_last)
  );
  assign load = !pix_valid || pix_ready;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end
  // The counter stops on the last coordinate, so the address is always the next pixel to load.
  always_comb begin
    next_state = state;
    clear      = 1'b0;
    capture    = 1'b0;
    adv        = 1'b0;
    finish     = 1'b0;
    if (abort) next_state = IDLE;
    else begin
      case (state)
        IDLE: begin
          clear      = start;
          next_state = start ? FETCH : IDLE;
        end
        FETCH: begin
          capture    = load;
          adv        = load && !at_last;
          next_state = (load && at_last) ? DRAIN : FETCH;
        end
        DRAIN: begin
          finish     = pix_valid && pix_ready;
          next_state = finish ? IDLE : DRAIN;
        end
        default: next_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memorySelect <= '0;
      pix_valid    <= 1'b0;
      pix_data     <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
      pix_last     <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= finish;
      if (clear) memorySelect <= sel_in;
      if (abort) pix_valid <= 1'b0;
      else if (capture) begin
        pix_valid <= 1'b1;
        pix_data  <= pixel;
        pix_x     <= xoff;
        pix_y     <= yoff;
        pix_last  <= at_last;
      end else if (finish) pix_valid <= 1'b0;
    end
  end
`ifdef ROM_SCAN_ONES_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ones_count <= '0;
    else if (clear)              ones_count <= '0;
    else if (capture && pixel)   ones_count <= ones_count + COUNT_W'(1);
  end
`else
  assign ones_count = '0;
`endif
endmodule

// File: tb/tb_rom_scan_controller.sv
// tb_rom_scan_controller: randomized self-checking bench against a pixel-list reference model
module tb_rom_scan_controller;
  import rom_scan_pkg::*;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [SEL_W-1:0]   sel_in = '0;
  logic [COORD_W-1:0] x_last = '0;
  logic [COORD_W-1:0] y_last = '0;
  logic [COORD_W-1:0] xoff, yoff, pix_x, pix_y;
  logic [SEL_W-1:0]   memorySelect;
  logic               pixel, pix_valid, pix_data, pix_last, busy, done;
  logic               pix_ready = 1'b1;
  logic [COUNT_W-1:0] ones_count;
  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  rom_scan_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sel_in(sel_in),
    .x_last(x_last), .y_last(y_last), .xoff(xoff), .yoff(yoff),
    .memorySelect(memorySelect), .pixel(pixel), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_last(pix_last), .busy(busy), .done(done), .ones_count(ones_count)
  );
  always #5 clk = ~clk;
  function automatic logic rom_f(input int s, input int x, input int y);
    logic [7:0] mask;
    mask = 8'b1011_0101;
    if (s == 2 && x < 4 && y < 2) return mask[y*4+x];
    return ((x * 3 + y * 5 + s) % 7) < 3;
  endfunction
  assign pixel = rom_f(int'(memorySelect), int'(xoff), int'(yoff));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: a scan is the row-major list of N window pixels; one sits on the
  // output at a time and the next is presented whenever the slot is empty or accepted.
  bit m_busy, m_valid, m_done;
  int m_sel, m_w, m_n, m_loaded, m_acc, m_ones, last_x, last_y;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_sel = 0; m_loaded = 0; m_ones = 0;
      m_w = 1; m_n = 1;
    end else begin
      m_done = 0;
      if (abort) begin
        m_busy = 0;
        m_valid = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_sel = int'(sel_in); m_w = int'(x_last) + 1;
          m_n = m_w * (int'(y_last) + 1); m_loaded = 0; m_ones = 0;
        end
      end else begin
        if (m_valid && pix_ready) begin
          m_acc++;
          last_x = (m_loaded - 1) % m_w;
          last_y = (m_loaded - 1) / m_w;
        end
        if (m_loaded < m_n && (!m_valid || pix_ready)) begin
          m_ones += int'(rom_f(m_sel, m_loaded % m_w, m_loaded / m_w));
          m_valid = 1;
          m_loaded++;
        end else if (m_valid && pix_ready) begin
          m_valid = 0; m_busy = 0; m_done = 1;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      int cur, nxt;
      cur = m_loaded - 1;
      nxt = (m_loaded < m_n) ? m_loaded : m_n - 1;
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("pix_valid", pix_valid, m_valid);
`ifdef ROM_SCAN_ONES_COUNT_EN
      chk("ones_count", ones_count, m_ones);
`else
      chk("ones_count", ones_count, 0);
`endif
      if (m_valid) begin
        chk("pix_x", pix_x, cur % m_w);
        chk("pix_y", pix_y, cur / m_w);
        chk("pix_data", pix_data, rom_f(m_sel, cur % m_w, cur / m_w));
        chk("pix_last", pix_last, m_loaded == m_n);
      end
      if (m_busy) begin
        chk("memorySelect", memorySelect, m_sel);
        chk("xoff", xoff, nxt % m_w);
        chk("yoff", yoff, nxt / m_w);
      end
    end
    pix_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ~pix_ready : 1'($urandom_range(0, 1));
  end
  task automatic pulse_start(input int s, input int xl, input int yl);
    @(posedge clk); #2;
    sel_in = SEL_W'(s); x_last = COORD_W'(xl); y_last = COORD_W'(yl); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask
  task automatic run_scan(input int s, input int xl, input int yl, output int cyc);
    @(posedge clk); #2;
    sel_in = SEL_W'(s); x_last = COORD_W'(xl); y_last = COORD_W'(yl); start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
    end while (!done && cyc < 70000);
    if (!done) chk("scan_timeout", 0, 1);
  endtask
  task automatic wait_acc(input int target);
    int n;
    n = 0;
    while (m_acc < target && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    if (m_acc < target) chk("accept_timeout", m_acc, target);
  endtask
  initial begin
    int cyc, a0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_xoff", xoff, 0);
    chk("rst_sel", memorySelect, 0);
    chk("rst_ones", ones_count, 0);
    ready_mode = 0;
    a0 = m_acc;
    run_scan(1, 3, 1, cyc);
    chk("t1_latency", cyc, 10);
    chk("t1_accepts", m_acc - a0, 8);
    chk("t1_last_x", last_x, 3);
    chk("t1_last_y", last_y, 1);
    chk("t1_sel_hold", memorySelect, 1);
    ready_mode = 1;
    a0 = m_acc;
    run_scan(1, 3, 1, cyc);
    chk("t2_accepts", m_acc - a0, 8);
    ready_mode = 0;
    a0 = m_acc;
    run_scan(5, 0, 0, cyc);
    chk("t3_latency", cyc, 3);
    chk("t3_accepts", m_acc - a0, 1);
    ready_mode = 2;
    run_scan(2, 3, 1, cyc);
`ifdef ROM_SCAN_ONES_COUNT_EN
    chk("pattern_ones", ones_count, 5);
`else
    chk("pattern_ones", ones_count, 0);
`endif
    for (int i = 0; i < 6; i++) begin
      a0 = m_acc;
      run_scan($urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 5), cyc);
      chk("rand_accepts", m_acc - a0, (int'(x_last) + 1) * (int'(y_last) + 1));
    end
    ready_mode = 0;
    a0 = m_acc;
    pulse_start(5, 7, 3);
    wait_acc(a0 + 3);
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    chk("abort_valid", pix_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    a0 = m_acc;
    run_scan(6, 2, 2, cyc);
    chk("rescan_accepts", m_acc - a0, 9);
    ready_mode = 2;
    pulse_start(3, 7, 3);
    repeat (4) @(posedge clk);
    #2 sel_in = 3'd6; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    chk("ignored_start_sel", memorySelect, 3);
    for (int n = 0; n < 500 && busy; n++) @(posedge clk);
    #2 chk("ignored_start_idle", busy, 0);
    ready_mode = 0;
    a0 = m_acc;
    run_scan(4, 255, 255, cyc);
    chk("big_accepts", m_acc - a0, 65536);
    chk("big_latency", cyc, 65538);
    chk("big_last_x", last_x, 255);
    chk("big_last_y", last_y, 255);
    ready_mode = 2;
    pulse_start(7, 5, 5);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_xoff", xoff, 0);
    chk("mid_rst_yoff", yoff, 0);
    chk("mid_rst_sel", memorySelect, 0);
    chk("mid_rst_valid", pix_valid, 0);
    chk("mid_rst_data", pix_data, 0);
    chk("mid_rst_px", pix_x, 0);
    chk("mid_rst_py", pix_y, 0);
    chk("mid_rst_last", pix_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ones", ones_count, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    a0 = m_acc;
    run_scan(1, 4, 2, cyc);
    chk("post_rst_accepts", m_acc - a0, 15);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
